// File: rtl/uart_tx_if.sv
// Byte handshake between a producer and the UART transmitter.
// The master offers a byte with in_valid; the slave accepts it when in_ready is high.
interface uart_tx_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/uart_tx.sv
// 8N1/8N2 UART transmitter: accepts a byte over a valid/ready handshake and
// serialises it LSB first, with a per-bit clock-enable counter and a registered tx line.
module uart_tx #(
  parameter int CLOCK_RATE = 12_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       rst,
  uart_tx_if.slave   bus,
  output logic       tx,
  output logic       busy
);

  localparam int CLKS_PER_BIT = CLOCK_RATE / BAUD_RATE;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic             STOP_LAST = (STOP_BITS == 2);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           r_state, w_stateNext;
  logic [CNT_W-1:0] r_cnt, w_cntNext;
  logic [2:0]       r_bitIdx, w_bitIdxNext;
  logic [7:0]       r_shift, w_shiftNext;
  logic             r_stopIdx, w_stopIdxNext;
  logic             r_tx, w_txNext;
  logic             w_bitDone;

  assign w_bitDone    = (r_cnt == CNT_LAST);
  assign bus.in_ready = (r_state == IDLE);
  assign busy         = (r_state != IDLE);
  assign tx           = r_tx;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_stateNext;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_bitIdx  <= '0;
      r_shift   <= '0;
      r_stopIdx <= 1'b0;
      r_tx      <= 1'b1;
    end else begin
      r_cnt     <= w_cntNext;
      r_bitIdx  <= w_bitIdxNext;
      r_shift   <= w_shiftNext;
      r_stopIdx <= w_stopIdxNext;
      r_tx      <= w_txNext;
    end
  end

  // The counter restarts at every bit boundary, which is also every state change.
  always_comb begin
    w_stateNext   = r_state;
    w_cntNext     = w_bitDone ? '0 : r_cnt + 1'b1;
    w_bitIdxNext  = r_bitIdx;
    w_shiftNext   = r_shift;
    w_stopIdxNext = r_stopIdx;
    w_txNext      = 1'b1;

    case (r_state)
      IDLE: begin
        w_cntNext = '0;
        if (bus.in_valid) begin
          w_stateNext   = START;
          w_shiftNext   = bus.in_data;
          w_bitIdxNext  = '0;
          w_stopIdxNext = 1'b0;
        end
      end
      START: begin
        if (w_bitDone) w_stateNext = DATA;
      end
      DATA: begin
        if (w_bitDone) begin
          if (r_bitIdx == 3'd7) begin
            w_stateNext = STOP;
          end else begin
            w_bitIdxNext = r_bitIdx + 3'd1;
            w_shiftNext  = r_shift >> 1;
          end
        end
      end
      STOP: begin
        if (w_bitDone) begin
          if (r_stopIdx == STOP_LAST) w_stateNext   = IDLE;
          else                        w_stopIdxNext = 1'b1;
        end
      end
    endcase

    // tx is computed from where the machine is going so the flop already holds it on entry.
    case (w_stateNext)
      IDLE:  w_txNext = 1'b1;
      START: w_txNext = 1'b0;
      DATA:  w_txNext = w_shiftNext[0];
      STOP:  w_txNext = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: two instances (1 and 2 stop bits) checked every cycle against a
// frame-position model, plus directed literal checks of waveforms and timings.
module tb_uart_tx;

  localparam int CPB = 4;

  logic clk;
  logic rst;
  logic txA, busyA, txB, busyB;

  uart_tx_if ifA();
  uart_tx_if ifB();

  uart_tx #(.CLOCK_RATE(16), .BAUD_RATE(4), .STOP_BITS(1)) dutA (
    .clk(clk), .rst(rst), .bus(ifA), .tx(txA), .busy(busyA)
  );
  uart_tx #(.CLOCK_RATE(16), .BAUD_RATE(4), .STOP_BITS(2)) dutB (
    .clk(clk), .rst(rst), .bus(ifB), .tx(txB), .busy(busyB)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int nChecks = 0;
  int nBad    = 0;
  logic checkEn = 1'b0;

  // Model: mPos is the cycle index inside the current frame, -1 when idle.
  int         mPos[2];
  logic [7:0] mByte[2];

  initial begin
    mPos[0] = -1;
    mPos[1] = -1;
    mByte[0] = '0;
    mByte[1] = '0;
  end

  function automatic int frameLen(input int d);
    return (9 + ((d == 1) ? 2 : 1)) * CPB;
  endfunction

  function automatic void modelStep(input int d, input logic v, input logic [7:0] dat);
    if (rst) begin
      mPos[d] = -1;
    end else if (mPos[d] >= 0) begin
      mPos[d] = mPos[d] + 1;
      if (mPos[d] == frameLen(d)) mPos[d] = -1;
    end else if (v) begin
      mPos[d]  = 0;
      mByte[d] = dat;
    end
  endfunction

  function automatic logic expTx(input int d);
    int slot;
    if (mPos[d] < 0) return 1'b1;
    slot = mPos[d] / CPB;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return mByte[d][slot-1];
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    modelStep(0, ifA.in_valid, ifA.in_data);
    modelStep(1, ifB.in_valid, ifB.in_data);
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nBad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("txA",    64'(txA),            64'(expTx(0)));
      checkOutput("busyA",  64'(busyA),          64'(mPos[0] >= 0));
      checkOutput("readyA", 64'(ifA.in_ready),   64'(mPos[0] < 0));
      checkOutput("txB",    64'(txB),            64'(expTx(1)));
      checkOutput("busyB",  64'(busyB),          64'(mPos[1] >= 0));
      checkOutput("readyB", 64'(ifB.in_ready),   64'(mPos[1] < 0));
    end
  end

  // Entered at a negedge; offers the byte for one cycle and returns at the first frame cycle.
  task automatic applyStimulus(input int d, input logic [7:0] dat);
    if (d == 0) begin ifA.in_data = dat; ifA.in_valid = 1'b1; end
    else        begin ifB.in_data = dat; ifB.in_valid = 1'b1; end
    @(negedge clk);
    if (d == 0) ifA.in_valid = 1'b0;
    else        ifB.in_valid = 1'b0;
  endtask

  task automatic captureFrame(input int d, input int n, output logic [63:0] wave,
                              output int busyCnt, output int readyLowCnt);
    wave = '0;
    busyCnt = 0;
    readyLowCnt = 0;
    for (int i = 0; i < n; i++) begin
      wave[i] = (d == 0) ? txA : txB;
      if (((d == 0) ? busyA : busyB) == 1'b1) busyCnt++;
      if (((d == 0) ? ifA.in_ready : ifB.in_ready) == 1'b0) readyLowCnt++;
      @(negedge clk);
    end
  endtask

  function automatic logic [15:0] slotsOf(input logic [63:0] w, input int n);
    logic [15:0] r;
    r = '0;
    for (int k = 0; k < n; k++) r[k] = w[4*k + 2];
    return r;
  endfunction

  initial begin
    logic [63:0] wave;
    int busyCnt, readyLowCnt, found, cnt;
    logic seenLow;

    rst = 1'b1;
    ifA.in_valid = 1'b0; ifA.in_data = '0;
    ifB.in_valid = 1'b0; ifB.in_data = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkOutput("reset_tx",    64'(txA),          64'd1);
    checkOutput("reset_busy",  64'(busyA),        64'd0);
    checkOutput("reset_ready", 64'(ifA.in_ready), 64'd1);
    checkOutput("reset_txB",   64'(txB),          64'd1);
    checkEn = 1'b1;
    @(negedge clk);

    $display("[TB] single byte A5");
    applyStimulus(0, 8'hA5);
    captureFrame(0, 48, wave, busyCnt, readyLowCnt);
    checkOutput("a5_slots",    64'(slotsOf(wave, 10)), 64'({1'b1, 8'hA5, 1'b0}));
    checkOutput("a5_start",    64'(wave[3:0]),         64'h0);
    checkOutput("a5_busy",     64'(busyCnt),           64'd40);
    checkOutput("a5_readyLow", 64'(readyLowCnt),       64'd40);

    $display("[TB] back-to-back 00 then FF");
    ifA.in_data = 8'h00; ifA.in_valid = 1'b1;
    @(negedge clk);
    ifA.in_data = 8'hFF;
    seenLow = 1'b0;
    found = -1;
    for (int t = 1; t <= 100; t++) begin
      @(negedge clk);
      if (!busyA) seenLow = 1'b1;
      else if (seenLow) begin
        found = t;
        break;
      end
    end
    ifA.in_valid = 1'b0;
    checkOutput("b2b_period", 64'(found), 64'd41);
    captureFrame(0, 48, wave, busyCnt, readyLowCnt);
    checkOutput("ff_slots", 64'(slotsOf(wave, 10)), 64'({1'b1, 8'hFF, 1'b0}));

    $display("[TB] mid-frame valid ignored");
    applyStimulus(0, 8'hC3);
    repeat (10) @(negedge clk);
    ifA.in_data = 8'h3C; ifA.in_valid = 1'b1;
    @(negedge clk);
    ifA.in_valid = 1'b0;
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      if (busyA) cnt++;
      @(negedge clk);
    end
    checkOutput("ignore_busyRest", 64'(cnt), 64'd29);

    $display("[TB] reset during data bit 3");
    applyStimulus(0, 8'h55);
    repeat (17) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_tx",   64'(txA),   64'd1);
    checkOutput("abort_busy", 64'(busyA), 64'd0);
    applyStimulus(0, 8'h0F);
    captureFrame(0, 48, wave, busyCnt, readyLowCnt);
    checkOutput("0f_slots", 64'(slotsOf(wave, 10)), 64'({1'b1, 8'h0F, 1'b0}));
    checkOutput("0f_busy",  64'(busyCnt),           64'd40);

    $display("[TB] reset beats handshake");
    rst = 1'b1;
    ifA.in_data = 8'hAA; ifA.in_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ifA.in_valid = 1'b0;
    checkOutput("rstPrio_busy", 64'(busyA), 64'd0);
    repeat (5) @(negedge clk);
    checkOutput("rstPrio_tx", 64'(txA), 64'd1);

    $display("[TB] two stop bits, byte 81");
    applyStimulus(1, 8'h81);
    captureFrame(1, 52, wave, busyCnt, readyLowCnt);
    checkOutput("s2_slots", 64'(slotsOf(wave, 11)), 64'({2'b11, 8'h81, 1'b0}));
    checkOutput("s2_stop",  64'(wave[43:36]),       64'hFF);
    checkOutput("s2_busy",  64'(busyCnt),           64'd44);

    repeat (4) @(negedge clk);
    checkEn = 1'b0;
    #1;
    $display("test done: total=%0d bad=%0d", nChecks, nBad);
    $finish;
  end

endmodule
